// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Results are registered on entry to DONE and held until the next division completes.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH:0]   rem_reg, rem_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] div_reg, div_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] quot_reg, quot_next;
    logic [WIDTH-1:0] remd_reg, remd_next;
    logic             dbz_reg, dbz_next;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        q_next     = q_reg;
        div_next   = div_reg;
        cnt_next   = cnt_reg;
        quot_next  = quot_reg;
        remd_next  = remd_reg;
        dbz_next   = dbz_reg;

        // The partial remainder never reaches 2^WIDTH, so the bit shifted out of rem is always 0.
        shifted = (rem_reg << 1) | {{WIDTH{1'b0}}, q_reg[WIDTH-1]};
        trial   = shifted - {1'b0, div_reg};

        case (state_reg)
            IDLE: begin
                if (start) begin
                    q_next   = dividend;
                    div_next = divisor;
                    rem_next = '0;
                    cnt_next = CW'(WIDTH);
                    dbz_next = 1'b0;
                    if (divisor == '0) begin
                        state_next = DONE;
                        quot_next  = '1;
                        remd_next  = dividend;
                        dbz_next   = 1'b1;
                    end else begin
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                // MSB of trial is the borrow: set means the subtraction went negative.
                if (!trial[WIDTH]) begin
                    rem_next = trial;
                    q_next   = {q_reg[WIDTH-2:0], 1'b1};
                end else begin
                    rem_next = shifted;
                    q_next   = {q_reg[WIDTH-2:0], 1'b0};
                end
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = DONE;
                    quot_next  = q_next;
                    remd_next  = rem_next[WIDTH-1:0];
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
            q_reg     <= '0;
            div_reg   <= '0;
            cnt_reg   <= '0;
            quot_reg  <= '0;
            remd_reg  <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            q_reg     <= q_next;
            div_reg   <= div_next;
            cnt_reg   <= cnt_next;
            quot_reg  <= quot_next;
            remd_reg  <= remd_next;
            dbz_reg   <= dbz_next;
        end
    end

    assign busy        = (state_reg == CALC);
    assign done        = (state_reg == DONE);
    assign quotient    = quot_reg;
    assign remainder   = remd_reg;
    assign div_by_zero = dbz_reg;

endmodule
